// File: rtl/rr_merge.sv
// rr_merge: round-robin merge of K valid-ready producer streams into one
// valid-ready stream. Each output item is tagged with its source index.
// The output is fully registered through a two-entry (main + skid) buffer,
// so input readies never depend combinationally on o_rdy.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset (overrides clk_en)
//   clk_en       - clock enable; when low all state holds, no handshakes
//   i_v[K]       - per-input valid
//   i_rdy[K]     - per-input ready (one-hot or zero)
//   i[K][W]      - per-input payload
//   o_v, o_rdy   - output handshake
//   o[W], o_id   - output payload and its source index
module rr_merge #(
  parameter  int W  = 1,
  parameter  int K  = 2,
  localparam int IW = $clog2(K)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic [K-1:0]        i_v,
  output logic [K-1:0]        i_rdy,
  input  logic [K-1:0][W-1:0] i,
  output logic                o_v,
  input  logic                o_rdy,
  output logic [W-1:0]        o,
  output logic [IW-1:0]       o_id
);

  generate
    if (W < 1) begin : g_bad_w
      $error("rr_merge: W must be positive");
    end
    if (K < 2) begin : g_bad_k
      $error("rr_merge: K must be at least 2");
    end
  endgenerate

  localparam logic [IW:0]   K_EXT  = (IW+1)'(K);
  localparam logic [IW-1:0] K_LAST = IW'(K - 1);

  logic          main_v, skid_v;
  logic [W-1:0]  main_d, skid_d;
  logic [IW-1:0] main_id, skid_id;
  logic [IW-1:0] ptr, ptr_nxt;

  logic [IW-1:0] g;
  logic          found;
  logic [IW:0]   scan;
  logic          accept;

  // Scan from ptr upward with wrap; first valid requester wins. The index
  // is kept one bit wider so the wrap works for non-power-of-two K.
  always_comb begin
    g     = '0;
    found = 1'b0;
    scan  = '0;
    for (int k = 0; k < K; k++) begin
      scan = {1'b0, ptr} + k[IW:0];
      if (scan >= K_EXT) scan = scan - K_EXT;
      if (!found && i_v[scan[IW-1:0]]) begin
        found = 1'b1;
        g     = scan[IW-1:0];
      end
    end
  end

  // Skid occupied means the buffer is full; accepting never looks at o_rdy.
  assign accept  = clk_en && !skid_v && (|i_v);
  assign ptr_nxt = (g == K_LAST) ? '0 : g + 1'b1;

  always_comb begin
    i_rdy = '0;
    for (int j = 0; j < K; j++)
      i_rdy[j] = accept && (g == IW'(j));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v  <= 1'b0;
      skid_v  <= 1'b0;
      ptr     <= '0;
      main_d  <= '0;
      main_id <= '0;
      skid_d  <= '0;
      skid_id <= '0;
    end else if (clk_en) begin
      if (accept) begin
        ptr <= ptr_nxt;
        if (!main_v || o_rdy) begin
          main_v  <= 1'b1;
          main_d  <= i[g];
          main_id <= g;
        end else begin
          // main is stalled: park the new item behind it
          skid_v  <= 1'b1;
          skid_d  <= i[g];
          skid_id <= g;
        end
      end else if (main_v && o_rdy) begin
        if (skid_v) begin
          main_d  <= skid_d;
          main_id <= skid_id;
          skid_v  <= 1'b0;
        end else begin
          main_v <= 1'b0;
        end
      end
    end
  end

  assign o_v  = main_v;
  assign o    = main_d;
  assign o_id = main_id;

endmodule

// File: tb/tb_rr_merge.sv
// Directed bench for rr_merge: a K=4/W=8 instance carries most tests, a
// K=3/W=4 instance covers non-power-of-two wrap and work conservation.
module tb_rr_merge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clk_en;

  // K=4, W=8 instance
  logic [3:0]      a_v, a_rdy;
  logic [3:0][7:0] a_i;
  logic            a_ov, a_ordy;
  logic [7:0]      a_o;
  logic [1:0]      a_oid;

  // K=3, W=4 instance
  logic [2:0]      b_v, b_rdy;
  logic [2:0][3:0] b_i;
  logic            b_ov, b_ordy;
  logic [3:0]      b_o;
  logic [1:0]      b_oid;

  rr_merge #(.W(8), .K(4)) u_a (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i_v(a_v), .i_rdy(a_rdy), .i(a_i),
    .o_v(a_ov), .o_rdy(a_ordy), .o(a_o), .o_id(a_oid)
  );

  rr_merge #(.W(4), .K(3)) u_b (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i_v(b_v), .i_rdy(b_rdy), .i(b_i),
    .o_v(b_ov), .o_rdy(b_ordy), .o(b_o), .o_id(b_oid)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one edge and settle past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic v, input logic [7:0] d, input logic [1:0] id);
    chk({tag, ".o_v"},  32'(a_ov),  32'(v));
    chk({tag, ".o"},    32'(a_o),   32'(d));
    chk({tag, ".o_id"}, 32'(a_oid), 32'(id));
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1;
    a_v = 4'b1111; a_ordy = 1'b1;
    for (int j = 0; j < 4; j++) a_i[j] = 8'h30 + 8'(j);
    b_v = 3'b000; b_ordy = 1'b1;
    for (int j = 0; j < 3; j++) b_i[j] = 4'h5 + 4'(j);

    // reset held two cycles with all inputs valid
    tick();
    chk_a("rst1", 1'b0, 8'h00, 2'd0);
    tick();
    chk_a("rst2", 1'b0, 8'h00, 2'd0);
    chk("rst.b_ov", 32'(b_ov), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.first_grant", 32'(a_rdy), 32'b0001);
    tick();
    chk_a("rst.first_out", 1'b1, 8'h30, 2'd0);
    a_v = 4'b0000;
    tick();
    chk("rst.drain", 32'(a_ov), 32'd0);

    // single item from input 2 (ptr is 1, work-conserving grant)
    a_v = 4'b0100; a_i[2] = 8'hA5;
    #1;
    chk("single.rdy", 32'(a_rdy), 32'b0100);
    tick();
    a_v = 4'b0000;
    #1;
    chk("single.rdy_idle", 32'(a_rdy), 32'b0000);
    chk_a("single.out", 1'b1, 8'hA5, 2'd2);
    tick();
    chk("single.gone", 32'(a_ov), 32'd0);
    a_i[2] = 8'h32;

    // reset to bring ptr back to 0
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // fairness: all valid, output ready, 8 cycles
    a_v = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("fair.rdy%0d", c), 32'(a_rdy), 32'(4'b0001 << (c % 4)));
      tick();
      chk_a($sformatf("fair.out%0d", c), 1'b1, 8'h30 + 8'(c % 4), 2'(c % 4));
    end
    a_v = 4'b0000;
    tick();
    chk("fair.drain", 32'(a_ov), 32'd0);

    // backpressure: fill main and skid, then drain with no bubble
    a_v = 4'b1111; a_ordy = 1'b0;
    #1;
    chk("bp.rdy0", 32'(a_rdy), 32'b0001);
    tick();
    chk("bp.rdy1", 32'(a_rdy), 32'b0010);
    tick();
    chk("bp.full_rdy", 32'(a_rdy), 32'b0000);
    chk_a("bp.hold1", 1'b1, 8'h30, 2'd0);
    tick();
    chk("bp.full_rdy2", 32'(a_rdy), 32'b0000);
    chk_a("bp.hold2", 1'b1, 8'h30, 2'd0);
    a_ordy = 1'b1;
    tick();
    chk_a("bp.out1", 1'b1, 8'h31, 2'd1);
    chk("bp.rdy_after_skid", 32'(a_rdy), 32'b0100);
    tick();
    chk_a("bp.out2", 1'b1, 8'h32, 2'd2);
    tick();
    chk_a("bp.out3", 1'b1, 8'h33, 2'd3);
    a_v = 4'b0000;
    tick();
    chk("bp.drain", 32'(a_ov), 32'd0);

    // clock enable low freezes everything
    a_v = 4'b1111;
    tick();
    chk_a("ce.pre", 1'b1, 8'h30, 2'd0);
    clk_en = 1'b0;
    #1;
    chk("ce.rdy", 32'(a_rdy), 32'b0000);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_a($sformatf("ce.frz%0d", c), 1'b1, 8'h30, 2'd0);
      chk($sformatf("ce.frz_rdy%0d", c), 32'(a_rdy), 32'b0000);
    end
    clk_en = 1'b1;
    #1;
    chk("ce.resume_rdy", 32'(a_rdy), 32'b0010);
    tick();
    chk_a("ce.resume", 1'b1, 8'h31, 2'd1);
    a_v = 4'b0000;
    tick();

    // K=3 wrap: ids 0,1,2,0
    b_v = 3'b111;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("k3.rdy%0d", c), 32'(b_rdy), 32'(3'b001 << (c % 3)));
      tick();
      chk($sformatf("k3.id%0d", c), 32'(b_oid), 32'(c % 3));
      chk($sformatf("k3.d%0d", c), 32'(b_o), 32'(4'h5 + 4'(c % 3)));
    end
    // ptr is 1 now; lone requester 0 granted at once
    b_v = 3'b001;
    #1;
    chk("k3.lone_rdy", 32'(b_rdy), 32'b001);
    tick();
    chk("k3.lone_id", 32'(b_oid), 32'd0);
    chk("k3.lone_v", 32'(b_ov), 32'd1);
    b_v = 3'b000;
    tick();
    chk("k3.drain", 32'(b_ov), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
